// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - control unit to datapath signal bundle
interface mc_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS main control state machine
module mc_control (
    input  logic        clk,
    input  logic        reset,
    mc_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state_q;
    state_t     nxt;
    logic       fetch_q;
    logic       decode_q;
    logic       pc_write_q;
    logic       pc_write_cond_q;
    logic       iord_q;
    logic       mem_read_q;
    logic       mem_write_q;
    logic       mem_to_reg_q;
    logic       reg_dst_q;
    logic       reg_write_q;
    logic       alu_src_a_q;
    logic [1:0] alu_src_b_q;
    logic [1:0] alu_op_q;
    logic [1:0] pc_source_q;
    logic       op_legal;

    // Opcodes that DECODE knows how to dispatch
    always_comb begin
        op_legal = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // Next-state selection; stalls hold on mem_ready low, stray codes fall to IDLE
    always_comb begin
        nxt = S_IDLE;
        case (state_q)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDIEX;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEMADR: nxt = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_ALUWB;
            S_ADDIEX: nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: nxt = S_FETCH;
            default:  nxt = S_IDLE;
        endcase
    end

    // State register with Moore outputs decoded one edge early from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            fetch_q         <= 1'b0;
            decode_q        <= 1'b0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            iord_q          <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_dst_q       <= 1'b0;
            reg_write_q     <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            alu_op_q        <= 2'b00;
            pc_source_q     <= 2'b00;
        end else begin
            state_q         <= nxt;
            fetch_q         <= 1'b0;
            decode_q        <= 1'b0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            iord_q          <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_dst_q       <= 1'b0;
            reg_write_q     <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            alu_op_q        <= 2'b00;
            pc_source_q     <= 2'b00;
            case (nxt)
                S_FETCH: begin
                    fetch_q     <= 1'b1;
                    mem_read_q  <= 1'b1;
                    alu_src_b_q <= 2'b01;
                end
                S_DECODE: begin
                    decode_q    <= 1'b1;
                    alu_src_b_q <= 2'b11;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a_q <= 1'b1;
                    alu_src_b_q <= 2'b10;
                end
                S_MEMRD: begin
                    mem_read_q <= 1'b1;
                    iord_q     <= 1'b1;
                end
                S_MEMWB: begin
                    reg_write_q  <= 1'b1;
                    mem_to_reg_q <= 1'b1;
                end
                S_MEMWR: begin
                    mem_write_q <= 1'b1;
                    iord_q      <= 1'b1;
                end
                S_EXEC: begin
                    alu_src_a_q <= 1'b1;
                    alu_op_q    <= 2'b10;
                end
                S_ALUWB: begin
                    reg_write_q <= 1'b1;
                    reg_dst_q   <= 1'b1;
                end
                S_ADDIWB: begin
                    reg_write_q <= 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_q     <= 1'b1;
                    alu_op_q        <= 2'b01;
                    pc_write_cond_q <= 1'b1;
                    pc_source_q     <= 2'b01;
                end
                S_JUMP: begin
                    pc_write_q  <= 1'b1;
                    pc_source_q <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    // IR and PC only update on the fetch cycle where memory actually delivers
    assign bus.ir_write      = fetch_q & bus.mem_ready;
    assign bus.pc_write      = pc_write_q | (fetch_q & bus.mem_ready);
    assign bus.pc_write_cond = pc_write_cond_q;
    assign bus.iord          = iord_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_to_reg    = mem_to_reg_q;
    assign bus.reg_dst       = reg_dst_q;
    assign bus.reg_write     = reg_write_q;
    assign bus.alu_src_a     = alu_src_a_q;
    assign bus.alu_src_b     = alu_src_b_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.pc_source     = pc_source_q;
    assign bus.illegal_op    = decode_q & ~op_legal;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed self-checking bench for mc_control
module tb_mc_control;
    logic clk;
    logic reset;
    mc_control_if bus ();

    mc_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout:
    // pc_write pc_write_cond iord mem_read mem_write ir_write mem_to_reg reg_dst reg_write
    // alu_src_a alu_src_b[2] alu_op[2] pc_source[2] illegal_op state[4]
    localparam logic [20:0] E_IDLE    = 21'b0;
    localparam logic [20:0] E_FETCH   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,4'd1};
    localparam logic [20:0] E_FETCHW  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,4'd1};
    localparam logic [20:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,4'd2};
    localparam logic [20:0] E_DECILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,4'd2};
    localparam logic [20:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,4'd3};
    localparam logic [20:0] E_MEMRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,4'd4};
    localparam logic [20:0] E_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,4'd5};
    localparam logic [20:0] E_MEMWR   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,4'd6};
    localparam logic [20:0] E_EXEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,4'd7};
    localparam logic [20:0] E_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,4'd8};
    localparam logic [20:0] E_BRANCH  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,4'd9};
    localparam logic [20:0] E_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,4'd10};
    localparam logic [20:0] E_ADDIEX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,4'd11};
    localparam logic [20:0] E_ADDIWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,4'd12};

    int checks   = 0;
    int failures = 0;

    function automatic logic [20:0] observed();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op, bus.state};
    endfunction

    task automatic check(input string tag, input logic [20:0] exp);
        logic [20:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: apply mem_ready, check the current state, advance one clock
    task automatic cyc(input string tag, input logic mr, input logic [20:0] exp);
        bus.mem_ready = mr;
        #1;
        check(tag, exp);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b100011;
        #12;
        check("reset_hold", E_IDLE);
        @(negedge clk);
        reset = 1'b0;

        // lw: 0,1,2,3,4,5,1
        cyc("lw_idle",   1'b1, E_IDLE);
        cyc("lw_fetch",  1'b1, E_FETCH);
        cyc("lw_decode", 1'b1, E_DECODE);
        cyc("lw_memadr", 1'b1, E_MEMADR);
        cyc("lw_memrd",  1'b1, E_MEMRD);
        cyc("lw_memwb",  1'b1, E_MEMWB);

        // sw with a fetch stall and two MEMWR wait cycles
        bus.opcode = 6'b101011;
        cyc("sw_fetch_wait", 1'b0, E_FETCHW);
        cyc("sw_fetch",      1'b1, E_FETCH);
        cyc("sw_decode",     1'b1, E_DECODE);
        cyc("sw_memadr",     1'b1, E_MEMADR);
        cyc("sw_memwr0",     1'b0, E_MEMWR);
        cyc("sw_memwr1",     1'b0, E_MEMWR);
        cyc("sw_memwr2",     1'b1, E_MEMWR);

        // beq then j, 3 cycles each
        bus.opcode = 6'b000100;
        cyc("beq_fetch",  1'b1, E_FETCH);
        cyc("beq_decode", 1'b1, E_DECODE);
        cyc("beq_branch", 1'b1, E_BRANCH);
        bus.opcode = 6'b000010;
        cyc("j_fetch",  1'b1, E_FETCH);
        cyc("j_decode", 1'b1, E_DECODE);
        cyc("j_jump",   1'b1, E_JUMP);

        // R-type then addi
        bus.opcode = 6'b000000;
        cyc("r_fetch",  1'b1, E_FETCH);
        cyc("r_decode", 1'b1, E_DECODE);
        cyc("r_exec",   1'b1, E_EXEC);
        cyc("r_aluwb",  1'b1, E_ALUWB);
        bus.opcode = 6'b001000;
        cyc("addi_fetch",  1'b1, E_FETCH);
        cyc("addi_decode", 1'b1, E_DECODE);
        cyc("addi_ex",     1'b1, E_ADDIEX);
        cyc("addi_wb",     1'b1, E_ADDIWB);

        // illegal opcode returns straight to FETCH
        bus.opcode = 6'b111111;
        cyc("ill_fetch",  1'b1, E_FETCH);
        cyc("ill_decode", 1'b1, E_DECILL);

        // lw interrupted by reset in a stalled MEMRD
        bus.opcode = 6'b100011;
        cyc("rst_fetch",  1'b1, E_FETCH);
        cyc("rst_decode", 1'b1, E_DECODE);
        cyc("rst_memadr", 1'b1, E_MEMADR);
        bus.mem_ready = 1'b0;
        #1;
        check("rst_memrd", E_MEMRD);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", E_IDLE);
        @(negedge clk);
        check("rst_held_edge", E_IDLE);
        reset = 1'b0;
        cyc("rst_idle",  1'b1, E_IDLE);
        cyc("rst_refetch", 1'b1, E_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle MIPS main control unit: a Moore-style state machine (Mealy only on `mem_ready` in memory states) that sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and enable. This includes the 2-bit `pc_source` and `alu_src_b` selects that feed the 32-bit 3:1 and 4:1 datapath multiplexers. It sits between the instruction register's opcode field and the datapath.

## Interface
- No parameters; opcode map and state encoding fixed below.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces state IDLE.
- `opcode` in 6: IR[31:26], stable from DECODE until the next FETCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `iord`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a` out 1: datapath enables and 2:1 selects.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = funct-decoded.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target; 11 is never driven.
- `illegal_op` out 1: high during DECODE when the opcode is unsupported.
- `state` out 4: current state, for debug.

## Operation
- State encoding:
  - 0 IDLE, 1 FETCH, 2 DECODE, 3 MEMADR, 4 MEMRD, 5 MEMWB
  - 6 MEMWR, 7 EXEC, 8 ALUWB, 9 BRANCH, 10 JUMP, 11 ADDIEX, 12 ADDIWB
  - Codes 13–15 are unused and go to IDLE on the next edge.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH→DECODE when `mem_ready`; otherwise hold.
  - DECODE branches on opcode:
    - lw and sw → MEMADR
    - R-type → EXEC
    - beq → BRANCH
    - j → JUMP
    - addi → ADDIEX
    - any other opcode → FETCH, with `illegal_op` high.
  - MEMADR→MEMRD for lw, →MEMWR for sw.
  - MEMRD→MEMWB when `mem_ready`; otherwise hold.
  - MEMWR→FETCH when `mem_ready`; otherwise hold.
  - EXEC→ALUWB and ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.
- Outputs per state (any output not listed is 0):
  - IDLE: all outputs 0.
  - FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00, `ir_write`=`mem_ready`, `pc_write`=`mem_ready`.
  - DECODE: `alu_src_b`=11, `alu_op`=00.
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEMRD: `mem_read`=1, `iord`=1.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - MEMWR: `mem_write`=1, `iord`=1.
  - EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - ALUWB: `reg_write`=1, `reg_dst`=1.
  - ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - JUMP: `pc_write`=1, `pc_source`=10.
- `pc_write` and `pc_write_cond` are never both 1.
- `mem_read` and `mem_write` are never both 1.

## Timing
- Reset: the state register asynchronously becomes IDLE, so all outputs are 0 and `state`=0 within the reset assertion, independent of `clk`.
- First FETCH follows on the first rising edge after `reset` deasserts.
- Instruction latency in cycles, with `mem_ready` held 1, counted FETCH to the next FETCH:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3
  - illegal opcode 2
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. During such a cycle:
  - all outputs hold their values;
  - `ir_write` and `pc_write` are 0 in FETCH, so PC and IR do not change.
- `opcode` is sampled only on the DECODE→next edge and on the MEMADR→next edge.
- Reset mid-instruction: the sequence is abandoned immediately and no further write enables assert until the next FETCH completes.

## Test plan
- Reset, then release with `mem_ready`=1 and opcode 100011 (lw) → `state` sequence 0,1,2,3,4,5,1; `reg_write`=1 and `mem_to_reg`=1 only in state 5.
- sw (101011) with `mem_ready` low for 2 cycles in MEMWR → `state` sequence 1,2,3,6,6,6,1; `mem_write`=1 for all three cycles in state 6, `iord`=1.
- beq (000100), then j (000010) → BRANCH shows `alu_op`=01, `pc_source`=01, `pc_write_cond`=1; JUMP shows `pc_source`=10, `pc_write`=1; each instruction takes 3 cycles.
- R-type (000000), then addi (001000) → EXEC shows `alu_op`=10 and `alu_src_b`=00; ALUWB shows `reg_dst`=1; ADDIEX shows `alu_src_b`=10; ADDIWB shows `reg_dst`=0.
- Opcode 111111 → `illegal_op`=1 during DECODE, then FETCH; no `reg_write`, `mem_write` or `pc_write` outside FETCH.
- Assert `reset` asynchronously mid-MEMRD, away from any clock edge → all outputs drop to 0 immediately, `state`=0; FETCH follows one edge after release.
